// File: rtl/audio_lab_pkg.sv
// Shared audio-lab definitions: SNR code values used by both the corrupter and the estimator,
// plus the estimator FSM encoding.
package audio_lab_pkg;

    localparam logic [2:0] SNR_NONE  = 3'b010;
    localparam logic [2:0] SNR_40DB  = 3'b001;
    localparam logic [2:0] SNR_30DB  = 3'b011;
    localparam logic [2:0] SNR_20DB  = 3'b111;
    localparam logic [2:0] SNR_10DB  = 3'b110;
    localparam logic [2:0] SNR_0DB   = 3'b100;
    localparam logic [2:0] SNR_M10DB = 3'b101;

    localparam logic [3:0] CMP_LAST = 4'd10;
    localparam logic [3:0] CMP_NONE = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } snr_state_t;

    // Each code covers two shift steps (~6 dB per step of noise_sum<<L).
    function automatic logic [2:0] snr_code_from_l(input logic [3:0] l);
        case (l)
            4'd0:       return SNR_M10DB;
            4'd1, 4'd2: return SNR_0DB;
            4'd3, 4'd4: return SNR_10DB;
            4'd5, 4'd6: return SNR_20DB;
            4'd7, 4'd8: return SNR_30DB;
            default:    return SNR_40DB;
        endcase
    endfunction

endpackage

// File: rtl/snr_estimator_abs_diff.sv
// Wrapping subtract (minuend - subtrahend) read as signed, plus its unsigned magnitude.
module abs_diff #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        minuend,
    input  logic [DATA_W-1:0]        subtrahend,
    output logic signed [DATA_W-1:0] diff,
    output logic [DATA_W-1:0]        mag
);

    logic [DATA_W-1:0] d_u;

    assign d_u  = minuend - subtrahend;
    assign diff = signed'(d_u);
    // Unsigned result keeps |-2**(DATA_W-1)| representable.
    assign mag  = d_u[DATA_W-1] ? -d_u : d_u;

endmodule

// File: rtl/snr_estimator.sv
// Windowed SNR estimator: accumulates |noise| and |signal| over 2**WIN_LOG2 samples, then finds
// the smallest shift L with (noise_sum<<L) >= sig_sum and maps it to the 3-bit SNR code.
//
// state   | meaning
// IDLE    | waiting for enable
// ACCUM   | accepting samples, summing magnitudes
// COMPARE | 11 cycles, one shift compare per cycle
// DONE    | one cycle, code_valid high
module snr_estimator
    import audio_lab_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] clean_left,
    input  logic [DATA_W-1:0] clean_right,
    input  logic [DATA_W-1:0] noisy_left,
    input  logic [DATA_W-1:0] noisy_right,
    output logic [2:0]        snr_code,
    output logic              code_valid,
    output logic              mismatch,
    output logic              busy
);

    localparam int SIG_W   = DATA_W + WIN_LOG2;
    localparam int NOISE_W = SIG_W + 11;

    snr_state_t state;

    logic [SIG_W-1:0]    sig_sum;
    logic [NOISE_W-1:0]  noise_sum;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [3:0]          cmp_l;
    logic [3:0]          l_hit;
    logic                l_found;
    logic                win_mm;

    logic signed [DATA_W-1:0] dl, dr;
    logic [DATA_W-1:0]        dl_mag, dr_mag, clean_mag;
    logic                     accept, lr_differ, cmp_hit;
    logic [3:0]               final_l;
    logic [2:0]               final_code;

    abs_diff #(.DATA_W(DATA_W)) u_diff_left (
        .minuend    (noisy_left),
        .subtrahend (clean_left),
        .diff       (dl),
        .mag        (dl_mag)
    );

    abs_diff #(.DATA_W(DATA_W)) u_diff_right (
        .minuend    (noisy_right),
        .subtrahend (clean_right),
        .diff       (dr),
        .mag        (dr_mag)
    );

    assign clean_mag    = clean_left[DATA_W-1] ? -clean_left : clean_left;
    assign lr_differ    = (dl != dr) || (dl_mag != dr_mag);
    assign sample_ready = (state == ST_ACCUM);
    assign busy         = (state == ST_ACCUM) || (state == ST_COMPARE);
    assign accept       = sample_valid && sample_ready;

    assign cmp_hit    = (noise_sum << cmp_l) >= {{(NOISE_W-SIG_W){1'b0}}, sig_sum};
    assign final_l    = l_found ? l_hit : (cmp_hit ? CMP_LAST : CMP_NONE);
    assign final_code = (noise_sum == '0) ? SNR_NONE : snr_code_from_l(final_l);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sig_sum    <= '0;
            noise_sum  <= '0;
            win_cnt    <= '0;
            cmp_l      <= '0;
            l_hit      <= '0;
            l_found    <= 1'b0;
            win_mm     <= 1'b0;
            snr_code   <= 3'b000;
            code_valid <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        sig_sum   <= '0;
                        noise_sum <= '0;
                        win_cnt   <= '1;
                        win_mm    <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        sig_sum   <= sig_sum + {{(SIG_W-DATA_W){1'b0}}, clean_mag};
                        noise_sum <= noise_sum + {{(NOISE_W-DATA_W){1'b0}}, dl_mag};
                        win_mm    <= win_mm | lr_differ;
                        if (win_cnt == '0) begin
                            cmp_l   <= '0;
                            l_found <= 1'b0;
                            state   <= ST_COMPARE;
                        end else begin
                            win_cnt <= win_cnt - 1'b1;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else begin
                        if (cmp_hit && !l_found) begin
                            l_found <= 1'b1;
                            l_hit   <= cmp_l;
                        end
                        if (cmp_l == CMP_LAST) begin
                            snr_code   <= final_code;
                            mismatch   <= win_mm;
                            code_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            cmp_l <= cmp_l + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    code_valid <= 1'b0;
                    if (enable) begin
                        sig_sum   <= '0;
                        noise_sum <= '0;
                        win_cnt   <= '1;
                        win_mm    <= 1'b0;
                        state     <= ST_ACCUM;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snr_estimator.sv
// Directed bench for snr_estimator: expected codes queued at stimulus time, checked at code_valid.
module tb_snr_estimator;
    import audio_lab_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, sample_valid;
    logic        sample_ready, code_valid, mismatch, busy;
    logic [31:0] clean_left, clean_right, noisy_left, noisy_right;
    logic [2:0]  snr_code;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    logic [31:0] sweep_noise [6] = '{32'h0100_0000, 32'h0040_0000, 32'h0010_0000,
                                     32'h0004_0000, 32'h0001_0000, 32'h0000_4000};
    logic [2:0]  sweep_code  [6] = '{SNR_M10DB, SNR_0DB, SNR_10DB,
                                     SNR_20DB, SNR_30DB, SNR_40DB};

    snr_estimator #(.DATA_W(32), .WIN_LOG2(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clean_left   (clean_left),
        .clean_right  (clean_right),
        .noisy_left   (noisy_left),
        .noisy_right  (noisy_right),
        .snr_code     (snr_code),
        .code_valid   (code_valid),
        .mismatch     (mismatch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one constant sample pattern until n_target samples are accepted; mm_idx marks
    // the one sample index whose right channel gets a different noise value (-1: none).
    task automatic drive(input logic [31:0] clean, input logic [31:0] noise, input int n_target,
                         input int mm_idx, input bit toggle, output int got);
        int guard = 0;
        got = 0;
        while (got < n_target && guard < 4000) begin
            @(posedge clk); #1;
            sample_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            clean_left   = clean;
            clean_right  = clean;
            noisy_left   = clean + noise;
            noisy_right  = clean + noise + ((got == mm_idx) ? 32'd1 : 32'd0);
            @(negedge clk);
            if (sample_valid && sample_ready) got++;
            guard++;
        end
    endtask

    task automatic run_window(input logic [31:0] clean, input logic [31:0] noise, input int mm_idx,
                              input bit toggle, input logic [2:0] exp_code, input logic exp_mm);
        int got;
        int k;
        logic [3:0] e;
        exp_q.push_back({exp_code, exp_mm});
        drive(clean, noise, 256, mm_idx, toggle, got);
        check("samples_accepted", got, 256);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 6) check("busy_in_compare", int'(busy), 1);
        end while (!code_valid && k < 40);
        check("code_valid_latency", k, 12);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
        check("snr_code", int'(snr_code), int'(e[3:1]));
        check("mismatch", int'(mismatch), int'(e[0]));
        check("busy_in_done", int'(busy), 0);
    endtask

    initial begin
        int got;
        int cv_seen;

        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        clean_left = '0; clean_right = '0; noisy_left = '0; noisy_right = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_snr_code", int'(snr_code), 0);
        check("reset_code_valid", int'(code_valid), 0);
        check("reset_mismatch", int'(mismatch), 0);
        check("reset_sample_ready", int'(sample_ready), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b1;

        // no noise
        run_window(32'h0100_0000, 32'h0, -1, 1'b0, SNR_NONE, 1'b0);

        // noise sweep
        for (int i = 0; i < 6; i++)
            run_window(32'h0100_0000, sweep_noise[i], -1, 1'b0, sweep_code[i], 1'b0);

        // negative signal and noise: magnitudes only
        run_window(32'hFF00_0000, 32'hFFFC_0000, -1, 1'b0, SNR_20DB, 1'b0);

        // single-sample left/right mismatch, then a clean window
        run_window(32'h0100_0000, 32'h0004_0000, 100, 1'b0, SNR_20DB, 1'b1);
        run_window(32'h0100_0000, 32'h0004_0000, -1, 1'b0, SNR_20DB, 1'b0);

        // enable dropped at sample 128
        drive(32'h0100_0000, 32'h0040_0000, 128, -1, 1'b0, got);
        check("abort_partial_count", got, 128);
        @(posedge clk); #1;
        enable = 1'b0;
        sample_valid = 1'b0;
        cv_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (code_valid) cv_seen++;
        end
        check("abort_no_code_valid", cv_seen, 0);
        check("abort_code_held", int'(snr_code), int'(SNR_20DB));
        check("abort_mismatch_held", int'(mismatch), 0);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_ready", int'(sample_ready), 0);
        enable = 1'b1;
        run_window(32'h0100_0000, 32'h0040_0000, -1, 1'b0, SNR_0DB, 1'b0);

        // reset pulsed mid-COMPARE
        drive(32'h0100_0000, 32'h0001_0000, 256, -1, 1'b0, got);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("midreset_snr_code", int'(snr_code), 0);
        check("midreset_code_valid", int'(code_valid), 0);
        check("midreset_mismatch", int'(mismatch), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(sample_ready), 0);
        reset = 1'b0;
        cv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (code_valid) cv_seen++;
        end
        check("midreset_no_code_valid", cv_seen, 0);
        check("midreset_code_zero", int'(snr_code), 0);
        enable = 1'b1;

        // 50% sample_valid: same window result as the continuous run
        run_window(32'h0100_0000, 32'h0004_0000, -1, 1'b1, SNR_20DB, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
